dmem_pipe: RTL

Parametrised, handshaked data memory for the pipeline's MEM stage. It replaces the fixed 1024-word, combinational-read memory with a block that has configurable width, depth and read latency. It also adds a valid/ready request channel, a one-cycle response pulse, byte-lane writes and out-of-range error reporting. One request is outstanding at a time, and the pipeline stalls on `req_ready`.

---
 rtl/dmem_pipe.sv | 129 ++++++++++++
 1 files changed

// File: rtl/dmem_pipe.sv
// Handshaked MEM-stage data memory: valid/ready requests, fixed-latency response pulse, range errors.
// Define DMEM_BYTE_EN to enable per-byte write lanes via req_be; otherwise writes update the full word.
module dmem_pipe #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [31:0]           req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_be,
  output logic                  resp_valid,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_err
);

  localparam int LANES = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t              state_reg, state_next;
  logic [3:0]          cnt_reg, cnt_next;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   rd_data_reg;
  logic                rd_ok_reg;
  logic                err_reg;
  logic                accept;
  logic                in_range;
  logic [ADDR_W-1:0]   index;
  logic [LANES-1:0]    lane_we;

  assign in_range   = (req_addr[31:ADDR_W] == '0);
  assign index      = req_addr[ADDR_W-1:0];
  assign req_ready  = !reset && (state_reg != WAIT);
  assign accept     = req_valid && req_ready;
  assign resp_valid = (state_reg == RESP);

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
`ifdef DMEM_BYTE_EN
    assign lane_we[gi] = req_be[gi];
`else
    assign lane_we[gi] = 1'b1;
`endif
  end

`ifndef DMEM_BYTE_EN
  logic unused_be;
  assign unused_be = ^req_be;
`endif

  // Storage and registered read port; kept free of reset so it maps onto block RAM.
  always_ff @(posedge clock) begin
    if (accept && req_we && in_range) begin
      for (int i = 0; i < LANES; i++) begin
        if (lane_we[i]) mem[index][i*8 +: 8] <= req_wdata[i*8 +: 8];
      end
    end
    if (accept && !req_we) rd_data_reg <= mem[index];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      rd_ok_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        rd_ok_reg <= !req_we && in_range;
        err_reg   <= !in_range;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE, RESP: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_next = RESP;
          end else begin
            state_next = WAIT;
            cnt_next   = 4'(LATENCY - 1);
          end
        end else if (state_reg == RESP) begin
          state_next = IDLE;
        end
      end
      WAIT: begin
        cnt_next = cnt_reg - 4'd1;
        if (cnt_next == 4'd0) state_next = RESP;
      end
      default: state_next = IDLE;
    endcase
  end

  // With single-cycle latency the captured registers only change on the edge that starts a
  // response, so they can drive the outputs directly; longer latencies need a holding stage.
  if (LATENCY == 1) begin : g_direct
    assign resp_rdata = rd_ok_reg ? rd_data_reg : '0;
    assign resp_err   = err_reg;
  end else begin : g_held
    logic [DATA_W-1:0] resp_rdata_reg;
    logic              resp_err_reg;

    always_ff @(posedge clock) begin
      if (reset) begin
        resp_rdata_reg <= '0;
        resp_err_reg   <= 1'b0;
      end else if (state_reg == WAIT && state_next == RESP) begin
        resp_rdata_reg <= rd_ok_reg ? rd_data_reg : '0;
        resp_err_reg   <= err_reg;
      end
    end

    assign resp_rdata = resp_rdata_reg;
    assign resp_err   = resp_err_reg;
  end

endmodule
